vib_alarm_multi: RTL and testbench

- Parametrised multi-channel vibration alarm detector, successor to the fixed 4-channel alarm searcher.
- Per channel: takes a max/min pair qualified by an update strobe and computes the peak-to-peak amplitude.
- Applies count-based hysteresis: N consecutive over-threshold samples raise the alarm; M consecutive under-threshold samples clear it.
- Sits between the per-channel max/min search blocks and the alarm/IO layer; thresholds are run-time programmable per channel.

---
 rtl/vib_alarm_multi.sv | 156 +++++++++++++++
 tb/tb_vib_alarm_multi.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vib_alarm_multi.sv
// Multi-channel vibration alarm: peak-to-peak amplitude vs per-channel threshold with count hysteresis.
// Optional sticky alarm latch enabled by defining VIB_ALARM_STICKY_EN.
module vib_alarm_multi #(
  parameter int NUM_CH   = 4,
  parameter int DW       = 16,
  parameter int HIGH_CNT = 10,
  parameter int LOW_CNT  = 5,
  parameter int CW       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH*DW-1:0] dat_max,
  input  logic [NUM_CH*DW-1:0] dat_min,
  input  logic [NUM_CH-1:0]    dat_max_en,
  input  logic [NUM_CH*DW-1:0] thr,
`ifdef VIB_ALARM_STICKY_EN
  input  logic                 sticky_clr,
  output logic [NUM_CH-1:0]    alarm_sticky,
`endif
  output logic [NUM_CH-1:0]    alarm,
  output logic [NUM_CH-1:0]    alarm_rise,
  output logic                 alarm_any
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ARMING   = 2'd1;
  localparam logic [1:0] ALARM    = 2'd2;
  localparam logic [1:0] CLEARING = 2'd3;

  localparam logic [CW:0] HIGH_T = (CW+1)'(HIGH_CNT);
  localparam logic [CW:0] LOW_T  = (CW+1)'(LOW_CNT);

  logic [NUM_CH-1:0] r0, r1, r2;
  logic [NUM_CH-1:0] ev;
  logic [NUM_CH-1:0] alarm_d;

  // The strobe may be asynchronous: two flops resynchronise it, the third detects its rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
    end else begin
      r0 <= dat_max_en;
      r1 <= r0;
      r2 <= r1;
    end
  end

  assign ev = r1 & ~r2;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DW-1:0] mx, mn, th, p2p;
    logic          hi;
    logic [1:0]    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   cnt_inc;

    assign mx      = dat_max[i*DW +: DW];
    assign mn      = dat_min[i*DW +: DW];
    assign th      = thr[i*DW +: DW];
    assign p2p     = (mx >= mn) ? (mx - mn) : '0;
    assign hi      = (p2p >= th);
    assign cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      case (st_q)
        IDLE: if (ev[i]) begin
          if (hi && HIGH_CNT == 1) begin
            st_d  = ALARM;
            cnt_d = '0;
          end else if (hi) begin
            st_d  = ARMING;
            cnt_d = CW'(1);
          end else begin
            cnt_d = '0;
          end
        end
        ARMING: if (ev[i]) begin
          if (!hi) begin
            st_d  = IDLE;
            cnt_d = '0;
          end else if (cnt_inc == HIGH_T) begin
            st_d  = ALARM;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc[CW-1:0];
          end
        end
        ALARM: if (ev[i] && !hi) begin
          if (LOW_CNT == 1) begin
            st_d  = IDLE;
            cnt_d = '0;
          end else begin
            st_d  = CLEARING;
            cnt_d = CW'(1);
          end
        end
        CLEARING: if (ev[i]) begin
          if (hi) begin
            st_d  = ALARM;
            cnt_d = '0;
          end else if (cnt_inc == LOW_T) begin
            st_d  = IDLE;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc[CW-1:0];
          end
        end
        default: begin
          st_d  = IDLE;
          cnt_d = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        st_q  <= IDLE;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    assign alarm_d[i] = (st_d == ALARM) || (st_d == CLEARING);
  end

  // Outputs are registered from next-state so alarm, alarm_any and the rise pulse line up with the state edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm      <= '0;
      alarm_rise <= '0;
      alarm_any  <= 1'b0;
    end else begin
      alarm      <= alarm_d;
      alarm_rise <= alarm_d & ~alarm;
      alarm_any  <= |alarm_d;
    end
  end

`ifdef VIB_ALARM_STICKY_EN
  // A new rise wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm_sticky <= '0;
    end else begin
      alarm_sticky <= (alarm_sticky & ~{NUM_CH{sticky_clr}}) | (alarm_d & ~alarm);
    end
  end
`endif

endmodule

// File: tb/tb_vib_alarm_multi.sv
// Scoreboard bench for vib_alarm_multi: directed plan cases, then randomized strobes vs a run-length model.
module tb_vib_alarm_multi;
  localparam int NUM_CH   = 4;
  localparam int DW       = 16;
  localparam int HIGH_CNT = 10;
  localparam int LOW_CNT  = 5;
  localparam int CW       = 8;

  typedef struct {
    int                cyc;
    logic [NUM_CH-1:0] alarm;
    logic [NUM_CH-1:0] rise;
    logic              any;
    string             tag;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_CH*DW-1:0] dat_max = '0;
  logic [NUM_CH*DW-1:0] dat_min = '0;
  logic [NUM_CH-1:0]    dat_max_en = '0;
  logic [NUM_CH*DW-1:0] thr = '0;
  logic [NUM_CH-1:0]    alarm;
  logic [NUM_CH-1:0]    alarm_rise;
  logic                 alarm_any;
`ifdef VIB_ALARM_STICKY_EN
  logic                 sticky_clr = 1'b0;
  logic [NUM_CH-1:0]    alarm_sticky;
`endif

  logic [NUM_CH*DW-1:0] mx_v, mn_v, thr_v;
  exp_t sb_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   m_alarm[NUM_CH];
  int   m_run[NUM_CH];

  vib_alarm_multi #(
    .NUM_CH(NUM_CH), .DW(DW), .HIGH_CNT(HIGH_CNT), .LOW_CNT(LOW_CNT), .CW(CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dat_max    (dat_max),
    .dat_min    (dat_min),
    .dat_max_en (dat_max_en),
    .thr        (thr),
`ifdef VIB_ALARM_STICKY_EN
    .sticky_clr   (sticky_clr),
    .alarm_sticky (alarm_sticky),
`endif
    .alarm      (alarm),
    .alarm_rise (alarm_rise),
    .alarm_any  (alarm_any)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare the queue head when its cycle comes up.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      if (sb_q[0].cyc < cyc) begin
        n_cmp++;
        n_err++;
        $display("[TB] FAIL %s: expected at cycle %0d, not checked (now %0d)", sb_q[0].tag, sb_q[0].cyc, cyc);
        void'(sb_q.pop_front());
      end else if (sb_q[0].cyc == cyc) begin
        exp_t e;
        e = sb_q.pop_front();
        n_cmp++;
        if (alarm !== e.alarm || alarm_rise !== e.rise || alarm_any !== e.any) begin
          n_err++;
          $display("[TB] FAIL %s @%0d: got alarm=%b rise=%b any=%b, want alarm=%b rise=%b any=%b",
                   e.tag, cyc, alarm, alarm_rise, alarm_any, e.alarm, e.rise, e.any);
        end
      end
    end
  end

  function automatic logic [NUM_CH-1:0] model_vec();
    logic [NUM_CH-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[i] = m_alarm[i];
    return v;
  endfunction

  task automatic set_ch(input int ch, input logic [DW-1:0] mx, input logic [DW-1:0] mn);
    mx_v[ch*DW +: DW] = mx;
    mn_v[ch*DW +: DW] = mn;
  endtask

  // One strobe rise on the masked channels; data held for the full 4-cycle slot.
  task automatic issue(input logic [NUM_CH-1:0] mask, input string tag);
    logic [NUM_CH-1:0] prev, nxt;
    logic [DW-1:0]     a, b, t;
    int                p, c;
    @(negedge clk);
    dat_max    = mx_v;
    dat_min    = mn_v;
    thr        = thr_v;
    dat_max_en = mask;
    c          = cyc;
    prev       = model_vec();
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i]) begin
        a = mx_v[i*DW +: DW];
        b = mn_v[i*DW +: DW];
        t = thr_v[i*DW +: DW];
        p = (int'(a) > int'(b)) ? int'(a) - int'(b) : 0;
        if ((p >= int'(t)) != m_alarm[i]) m_run[i]++;
        else m_run[i] = 0;
        if (!m_alarm[i] && m_run[i] == HIGH_CNT) begin
          m_alarm[i] = 1'b1;
          m_run[i]   = 0;
        end else if (m_alarm[i] && m_run[i] == LOW_CNT) begin
          m_alarm[i] = 1'b0;
          m_run[i]   = 0;
        end
      end
    end
    nxt = model_vec();
    sb_q.push_back('{c + 3, nxt, nxt & ~prev, |nxt, tag});
    sb_q.push_back('{c + 4, nxt, '0, |nxt, {tag, "/after"}});
    repeat (2) @(negedge clk);
    dat_max_en = '0;
    @(negedge clk);
  endtask

  task automatic drain();
    int g = 0;
    while (sb_q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL drain: %0d entries still pending, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic do_reset();
    drain();
    @(negedge clk);
    rst        = 1'b0;
    dat_max_en = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_alarm[i] = 1'b0;
      m_run[i]   = 0;
    end
    sb_q.push_back('{cyc + 1, '0, '0, 1'b0, "reset"});
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    mx_v  = '0;
    mn_v  = '0;
    thr_v = {NUM_CH{16'h8000}};
    do_reset();

    set_ch(0, 16'hF000, 16'h1000);
    for (int k = 0; k < 9; k++) issue(4'b0001, "ch0_high_pre");
    issue(4'b0001, "ch0_high_10th");

    set_ch(1, 16'hF000, 16'h1000);
    for (int k = 0; k < 9; k++) issue(4'b0010, "ch1_high_a");
    set_ch(1, 16'h8FFF, 16'h1000);
    issue(4'b0010, "ch1_low_7fff");
    set_ch(1, 16'hF000, 16'h1000);
    for (int k = 0; k < 9; k++) issue(4'b0010, "ch1_high_b");

    set_ch(0, 16'h2000, 16'h1000);
    for (int k = 0; k < 4; k++) issue(4'b0001, "ch0_low_a");
    set_ch(0, 16'hF000, 16'h1000);
    issue(4'b0001, "ch0_high_mid");
    set_ch(0, 16'h2000, 16'h1000);
    for (int k = 0; k < 5; k++) issue(4'b0001, "ch0_low_b");

    thr_v[2*DW +: DW] = 16'h0000;
    set_ch(2, 16'h1000, 16'h2000);
    set_ch(3, 16'h9000, 16'h1000);
    for (int k = 0; k < 10; k++) issue(4'b1100, "bound_eq_thr0");
    set_ch(3, 16'h1000, 16'h2000);
    for (int k = 0; k < 5; k++) issue(4'b1100, "bound_nowrap");

    do_reset();
    thr_v = {NUM_CH{16'h8000}};
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 16'hF000, 16'h1000);
    for (int k = 0; k < 5; k++) issue(4'b1111, "all_arming");
    do_reset();
    for (int k = 0; k < 10; k++) issue(4'b1111, "all_after_reset");

    for (int n = 0; n < 200; n++) begin
      int bias;
      bias = ((n / 40) % 2 == 0) ? 85 : 25;
      if ($urandom_range(0, 19) == 0) begin
        for (int i = 0; i < NUM_CH; i++) begin
          case ($urandom_range(0, 3))
            0:       thr_v[i*DW +: DW] = 16'h0000;
            1:       thr_v[i*DW +: DW] = 16'h4000;
            default: thr_v[i*DW +: DW] = 16'h8000;
          endcase
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        logic [DW-1:0] mn, p;
        mn = DW'($urandom_range(0, 16'h3000));
        if ($urandom_range(0, 9) == 0) begin
          set_ch(i, mn, mn + DW'($urandom_range(1, 16'h1000)));
        end else begin
          if ($urandom_range(0, 99) < bias) p = DW'($urandom_range(16'h7FF0, 16'hBFFF));
          else p = DW'($urandom_range(0, 16'h8010));
          set_ch(i, mn + p, mn);
        end
      end
      issue(4'($urandom_range(1, 15)), "random");
    end

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
